// File: rtl/ifu_pkg.sv
// Shared state encoding, default widths and helpers for the instruction fetch unit.
// Optional fetch counter is enabled with IFU_FETCH_COUNT_EN.
package ifu_pkg;

    localparam int          IFU_DATA_WIDTH = 16;
    localparam int          IFU_ADDR_WIDTH = 10;
    localparam int unsigned IFU_RESET_PC   = 32'd0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } ifu_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ifu_pc_counter.sv
// Program counter: async reset to RESET_PC, load has priority over increment,
// increment wraps modulo 2^ADDR_WIDTH.
module ifu_pc_counter
    import ifu_pkg::*;
#(
    parameter int          ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned RESET_PC   = IFU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_pc
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_V = ADDR_WIDTH'(RESET_PC);

    logic [ADDR_WIDTH-1:0] r_pc;

    // PC register with load-over-increment priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC_V;
        end else if (i_load) begin
            r_pc <= i_load_addr;
        end else if (i_inc) begin
            r_pc <= r_pc + ADDR_WIDTH'(1);
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: FETCH/WAIT/HOLD sequencer feeding the CPU control FSM.
// Define IFU_FETCH_COUNT_EN to add the saturating fetch_count output.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DATA_WIDTH = IFU_DATA_WIDTH,
    parameter int          ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int unsigned RESET_PC   = IFU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PC_enable,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_addr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] instruction_out,
    output logic                  instr_valid,
`ifdef IFU_FETCH_COUNT_EN
    output logic [15:0]           fetch_count,
`endif
    output logic [ADDR_WIDTH-1:0] pc_out
);

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_V = ADDR_WIDTH'(RESET_PC);

    ifu_state_e            r_state;
    ifu_state_e            w_state_nxt;
    logic                  w_inc;
    logic                  w_capture;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [ADDR_WIDTH-1:0] r_pc_out;
    logic                  r_valid;

    ifu_pc_counter #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .reset       (reset),
        .i_load      (pc_load),
        .i_load_addr (pc_load_addr),
        .i_inc       (w_inc),
        .o_pc        (w_pc)
    );

    // Next-state decode; pc_load flushes from any state and beats PC_enable
    always_comb begin
        w_state_nxt = r_state;
        w_inc       = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            FETCH: begin
                w_state_nxt = pc_load ? FETCH : WAIT;
            end
            WAIT: begin
                if (pc_load) begin
                    w_state_nxt = FETCH;
                end else begin
                    w_state_nxt = HOLD;
                    w_capture   = 1'b1;
                end
            end
            HOLD: begin
                if (pc_load) begin
                    w_state_nxt = FETCH;
                end else if (PC_enable) begin
                    w_state_nxt = FETCH;
                    w_inc       = 1'b1;
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output registers; mem_q is only looked at on the WAIT->HOLD capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr  <= {DATA_WIDTH{1'b0}};
            r_pc_out <= RESET_PC_V;
            r_valid  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_instr  <= mem_q;
                r_pc_out <= w_pc;
            end else begin
                r_instr  <= r_instr;
                r_pc_out <= r_pc_out;
            end
            r_valid <= (w_state_nxt == HOLD);
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] r_fetch_count;

    // Completed (non-flushed) fetches, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_count <= 16'd0;
        end else if (w_capture) begin
            r_fetch_count <= sat_inc16(r_fetch_count);
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign fetch_count = r_fetch_count;
`endif

    // Read strobe is masked by reset so it reads 0 while reset is held in FETCH
    assign mem_re          = (r_state == FETCH) & ~reset;
    assign mem_addr        = w_pc;
    assign instruction_out = r_instr;
    assign pc_out          = r_pc_out;
    assign instr_valid     = r_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus pushes expected words,
// a negedge monitor pops and compares on every rising instr_valid.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_enable;
    logic        pc_load;
    logic [9:0]  pc_load_addr;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic [15:0] mem_q;
    logic [15:0] instruction_out;
    logic        instr_valid;
    logic [9:0]  pc_out;
`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] fetch_count;
`endif

    logic [15:0] ram [0:1023];
    logic [25:0] exp_q [$];
    logic [25:0] exp_e;
    logic        prev_v = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc;

    always #5 clk = ~clk;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .PC_enable       (PC_enable),
        .pc_load         (pc_load),
        .pc_load_addr    (pc_load_addr),
        .mem_addr        (mem_addr),
        .mem_re          (mem_re),
        .mem_q           (mem_q),
        .instruction_out (instruction_out),
        .instr_valid     (instr_valid),
`ifdef IFU_FETCH_COUNT_EN
        .fetch_count     (fetch_count),
`endif
        .pc_out          (pc_out)
    );

    // Synchronous RAM with one-cycle read latency; X when no read was issued
    always @(posedge clk) begin
        if (mem_re === 1'b1) mem_q <= ram[mem_addr];
        else                 mem_q <= 16'hxxxx;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, output int cycles);
        bit seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            cycles++;
            if (instr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: instr_valid never rose within %0d cycles", name, cycles);
        end
    endtask

    // Monitor: compare each newly valid instruction against the scoreboard
    always @(negedge clk) begin
        if (instr_valid === 1'b1 && prev_v !== 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got instr %h pc %h, expected none", instruction_out, pc_out);
            end else begin
                exp_e = exp_q.pop_front();
                chk("mon_instr", 32'(instruction_out), 32'(exp_e[25:10]));
                chk("mon_pc", 32'(pc_out), 32'(exp_e[9:0]));
            end
        end
        if (instr_valid === 1'b1 && instruction_out === 16'hDEAD) begin
            n_tests++;
            n_fail++;
            $display("FAIL flushed_word_visible: got %h, expected anything but DEAD", instruction_out);
        end
        prev_v = instr_valid;
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0F00 ^ 16'(i);
        ram[10'h000] = 16'h1234;
        ram[10'h001] = 16'hABCD;
        ram[10'h002] = 16'h2222;
        ram[10'h200] = 16'h5555;
        ram[10'h201] = 16'hDEAD;
        ram[10'h050] = 16'h7777;
        ram[10'h3FF] = 16'h3FF3;

        reset = 1'b1; PC_enable = 1'b0; pc_load = 1'b0; pc_load_addr = 10'h000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instruction_out), 32'd0);
        chk("rst_pc_out", 32'(pc_out), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_re", 32'(mem_re), 32'd0);

        // First fetch from address 0
        exp_q.push_back({16'h1234, 10'h000});
        reset = 1'b0;
        #1;
        chk("fetch0_mem_re", 32'(mem_re), 32'd1);
        chk("fetch0_mem_addr", 32'(mem_addr), 32'd0);
        wait_valid("fetch0", cyc);
        chk("fetch0_latency", 32'(cyc), 32'd2);

        // Sequential advance
        exp_q.push_back({16'hABCD, 10'h001});
        PC_enable = 1'b1; step(); PC_enable = 1'b0;
        chk("adv_valid_drop", 32'(instr_valid), 32'd0);
        chk("adv_mem_addr", 32'(mem_addr), 32'h001);
        wait_valid("adv", cyc);
        chk("adv_latency", 32'(cyc), 32'd2);

        // pc_load beats PC_enable
        exp_q.push_back({16'h5555, 10'h200});
        pc_load = 1'b1; pc_load_addr = 10'h200; PC_enable = 1'b1;
        step();
        pc_load = 1'b0; PC_enable = 1'b0;
        chk("prio_mem_addr", 32'(mem_addr), 32'h200);
        wait_valid("prio", cyc);

        // Flush during WAIT: DEAD at 0x201 must be dropped
        exp_q.push_back({16'h7777, 10'h050});
        PC_enable = 1'b1; step(); PC_enable = 1'b0;
        chk("flush_fetch_addr", 32'(mem_addr), 32'h201);
        step();
        pc_load = 1'b1; pc_load_addr = 10'h050;
        step();
        pc_load = 1'b0;
        chk("flush_valid_low", 32'(instr_valid), 32'd0);
        chk("flush_mem_addr", 32'(mem_addr), 32'h050);
        wait_valid("flush", cyc);

        // Wrap from 1023 to 0
        exp_q.push_back({16'h3FF3, 10'h3FF});
        pc_load = 1'b1; pc_load_addr = 10'h3FF; step(); pc_load = 1'b0;
        wait_valid("load3ff", cyc);
        exp_q.push_back({16'h1234, 10'h000});
        PC_enable = 1'b1; step(); PC_enable = 1'b0;
        chk("wrap_mem_addr", 32'(mem_addr), 32'd0);
        wait_valid("wrap", cyc);

        // Asynchronous reset in the middle of WAIT (PC = 1)
        PC_enable = 1'b1; step(); PC_enable = 1'b0;
        step();
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("midrst_mem_re", 32'(mem_re), 32'd0);
        chk("midrst_pc_out", 32'(pc_out), 32'd0);
`ifdef IFU_FETCH_COUNT_EN
        chk("midrst_fetch_count", 32'(fetch_count), 32'd0);
`endif
        step();
        exp_q.push_back({16'h1234, 10'h000});
        reset = 1'b0;
        wait_valid("post_rst0", cyc);
        exp_q.push_back({16'hABCD, 10'h001});
        PC_enable = 1'b1; step(); PC_enable = 1'b0;
        wait_valid("post_rst1", cyc);
        exp_q.push_back({16'h2222, 10'h002});
        PC_enable = 1'b1; step(); PC_enable = 1'b0;
        wait_valid("post_rst2", cyc);
`ifdef IFU_FETCH_COUNT_EN
        chk("fetch_count_3", 32'(fetch_count), 32'd3);
`endif
        step();
        step();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
